calc_mmio_regs: RTL and testbench

Memory-mapped register responder for the calculator datapath. It services the FPGA keypad/display front end as one requester and the CPU data bus as a second requester, over one shared single-ported register set. It holds the operands, the operator and the result, plus a status word that tells each side when the other has finished. It sits between the front-end controller's address/data/enable outputs and the CPU load/store path.

---
 rtl/calc_mmio_regs.sv | 162 ++++++++++++++++
 tb/tb_calc_mmio_regs.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc_mmio_regs.sv
// calc_mmio_regs: shared register set for the calculator datapath, serving the
// FPGA front end and the CPU bus with one round-robin arbitrated access/cycle.
module calc_mmio_regs #(
  parameter logic [31:0] ADDR_NUM1   = 32'd220,
  parameter logic [31:0] ADDR_NUM2   = 32'd240,
  parameter logic [31:0] ADDR_OP     = 32'd260,
  parameter logic [31:0] ADDR_RESULT = 32'd280,
  parameter logic [31:0] ADDR_STATUS = 32'd300
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        nrst_fpga,
  input  logic        fpga_en,
  input  logic        fpga_write,
  input  logic [31:0] fpga_addr,
  input  logic [31:0] fpga_wdata,
  output logic [31:0] fpga_rdata,
  output logic        fpga_ack,
  input  logic        cpu_enable,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        result_ready
);

  typedef enum logic {
    GNT_CPU  = 1'b0,
    GNT_FPGA = 1'b1
  } grant_e;

  // STATUS bit positions
  localparam int unsigned ST_NUM1   = 0;
  localparam int unsigned ST_NUM2   = 1;
  localparam int unsigned ST_OP     = 2;
  localparam int unsigned ST_RESULT = 3;

  logic [31:0] num1_q, num1_d;
  logic [31:0] num2_q, num2_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] result_q, result_d;
  logic [3:0]  status_q, status_d;
  grant_e      last_grant_q, last_grant_d;
  logic        fpga_ack_q, fpga_ack_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [31:0] fpga_rdata_q, fpga_rdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;

  logic        fpga_req, cpu_req;
  logic        gnt_fpga, gnt_cpu;
  logic        acc_write;
  logic [31:0] acc_addr, acc_wdata;
  logic [31:0] rd_val;

  // Arbitration: FPGA wins a tie only when the CPU was granted last
  always_comb begin
    fpga_req  = fpga_en;
    cpu_req   = cpu_enable & (cpu_read | cpu_write);
    gnt_fpga  = fpga_req & (~cpu_req | (last_grant_q == GNT_CPU));
    gnt_cpu   = cpu_req & ~gnt_fpga;
    acc_addr  = gnt_fpga ? fpga_addr : cpu_addr;
    acc_wdata = gnt_fpga ? fpga_wdata : cpu_wdata;
    acc_write = (gnt_fpga & fpga_write) | (gnt_cpu & cpu_write);
  end

  // Read mux on the granted address, taken from pre-update register values
  always_comb begin
    rd_val = '0;
    if (acc_addr == ADDR_NUM1)        rd_val = num1_q;
    else if (acc_addr == ADDR_NUM2)   rd_val = num2_q;
    else if (acc_addr == ADDR_OP)     rd_val = {27'd0, op_q};
    else if (acc_addr == ADDR_RESULT) rd_val = result_q;
    else if (acc_addr == ADDR_STATUS) rd_val = {28'd0, status_q};
  end

  // Next-state: acks, read capture, register writes and soft clear
  always_comb begin
    num1_d       = num1_q;
    num2_d       = num2_q;
    op_d         = op_q;
    result_d     = result_q;
    status_d     = status_q;
    last_grant_d = last_grant_q;
    fpga_ack_d   = gnt_fpga;
    cpu_ack_d    = gnt_cpu;
    fpga_rdata_d = fpga_rdata_q;
    cpu_rdata_d  = cpu_rdata_q;

    if (gnt_fpga)     last_grant_d = GNT_FPGA;
    else if (gnt_cpu) last_grant_d = GNT_CPU;

    if (gnt_fpga && !fpga_write) fpga_rdata_d = rd_val;
    if (gnt_cpu && !cpu_write)   cpu_rdata_d  = rd_val;

    // Soft clear takes priority over any write granted in the same cycle
    if (!nrst_fpga) begin
      num1_d   = '0;
      num2_d   = '0;
      op_d     = '0;
      status_d = '0;
    end else if (acc_write) begin
      if (gnt_fpga) begin
        if (acc_addr == ADDR_NUM1) begin
          num1_d            = acc_wdata;
          status_d[ST_NUM1] = 1'b1;
        end else if (acc_addr == ADDR_NUM2) begin
          num2_d            = acc_wdata;
          status_d[ST_NUM2] = 1'b1;
        end else if (acc_addr == ADDR_OP) begin
          op_d            = acc_wdata[4:0];
          status_d[ST_OP] = 1'b1;
        end
      end else begin
        if (acc_addr == ADDR_NUM1)        num1_d = acc_wdata;
        else if (acc_addr == ADDR_NUM2)   num2_d = acc_wdata;
        else if (acc_addr == ADDR_OP)     op_d   = acc_wdata[4:0];
        else if (acc_addr == ADDR_RESULT) begin
          result_d            = acc_wdata;
          status_d[ST_RESULT] = 1'b1;
        end else if (acc_addr == ADDR_STATUS) begin
          status_d = status_q & ~acc_wdata[3:0];
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      num1_q       <= '0;
      num2_q       <= '0;
      op_q         <= '0;
      result_q     <= '0;
      status_q     <= '0;
      last_grant_q <= GNT_CPU;
      fpga_ack_q   <= 1'b0;
      cpu_ack_q    <= 1'b0;
      fpga_rdata_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      num1_q       <= num1_d;
      num2_q       <= num2_d;
      op_q         <= op_d;
      result_q     <= result_d;
      status_q     <= status_d;
      last_grant_q <= last_grant_d;
      fpga_ack_q   <= fpga_ack_d;
      cpu_ack_q    <= cpu_ack_d;
      fpga_rdata_q <= fpga_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign fpga_ack     = fpga_ack_q;
  assign cpu_ack      = cpu_ack_q;
  assign fpga_rdata   = fpga_rdata_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign result_ready = status_q[ST_RESULT];

endmodule

// File: tb/tb_calc_mmio_regs.sv
// tb_calc_mmio_regs: directed vector table, async-reset sequence, and
// randomized traffic against a behavioural register-map model.
module tb_calc_mmio_regs;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        nrst_fpga = 1'b1;
  logic        fpga_en = 1'b0, fpga_write = 1'b0;
  logic [31:0] fpga_addr = '0, fpga_wdata = '0;
  logic [31:0] fpga_rdata;
  logic        fpga_ack;
  logic        cpu_enable = 1'b0, cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        result_ready;

  int unsigned total = 0;
  int unsigned bad = 0;

  calc_mmio_regs #(
    .ADDR_NUM1(32'd220), .ADDR_NUM2(32'd240), .ADDR_OP(32'd260),
    .ADDR_RESULT(32'd280), .ADDR_STATUS(32'd300)
  ) dut (
    .clk(clk), .nrst(nrst), .nrst_fpga(nrst_fpga),
    .fpga_en(fpga_en), .fpga_write(fpga_write), .fpga_addr(fpga_addr),
    .fpga_wdata(fpga_wdata), .fpga_rdata(fpga_rdata), .fpga_ack(fpga_ack),
    .cpu_enable(cpu_enable), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit fen; bit fwr; logic [31:0] fa; logic [31:0] fd;
    bit cen; bit crd; bit cwr; logic [31:0] ca; logic [31:0] cd;
    bit nsc;
    bit e_fack; bit e_cack; logic [31:0] e_frd; logic [31:0] e_crd; bit e_rr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit fen, bit fwr, logic [31:0] fa, logic [31:0] fd,
                              bit cen, bit crd, bit cwr, logic [31:0] ca, logic [31:0] cd,
                              bit nsc, bit e_fack, bit e_cack,
                              logic [31:0] e_frd, logic [31:0] e_crd, bit e_rr);
    vec_t v;
    v.fen = fen; v.fwr = fwr; v.fa = fa; v.fd = fd;
    v.cen = cen; v.crd = crd; v.cwr = cwr; v.ca = ca; v.cd = cd; v.nsc = nsc;
    v.e_fack = e_fack; v.e_cack = e_cack; v.e_frd = e_frd; v.e_crd = e_crd; v.e_rr = e_rr;
    return v;
  endfunction

  task automatic drive(input bit fen, input bit fwr, input logic [31:0] fa, input logic [31:0] fd,
                       input bit cen, input bit crd, input bit cwr,
                       input logic [31:0] ca, input logic [31:0] cd, input bit nsc);
    fpga_en = fen; fpga_write = fwr; fpga_addr = fa; fpga_wdata = fd;
    cpu_enable = cen; cpu_read = crd; cpu_write = cwr; cpu_addr = ca; cpu_wdata = cd;
    nrst_fpga = nsc;
  endtask

  // Behavioural model: register map keyed by byte address, status as flag bits
  logic [31:0] m_reg [int unsigned];
  bit   [3:0]  m_stat;
  bit          m_fpga_turn;
  logic [31:0] m_frd, m_crd;

  function automatic void m_reset();
    m_reg.delete();
    m_reg[220] = '0; m_reg[240] = '0; m_reg[260] = '0; m_reg[280] = '0;
    m_stat = '0; m_fpga_turn = 1'b1; m_frd = '0; m_crd = '0;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    if (a == 32'd300) return {28'd0, m_stat};
    if (m_reg.exists(int'(a))) return m_reg[int'(a)];
    return '0;
  endfunction

  function automatic void m_write(bit from_fpga, logic [31:0] a, logic [31:0] d);
    int unsigned ai = a;
    logic [31:0] dv = (ai == 260) ? (d & 32'h1F) : d;
    if (from_fpga) begin
      if (ai == 220 || ai == 240 || ai == 260) begin
        m_reg[ai] = dv;
        m_stat[(ai - 220) / 20] = 1'b1;
      end
    end else begin
      if (ai == 300) m_stat = m_stat & ~d[3:0];
      else if (m_reg.exists(ai)) begin
        m_reg[ai] = dv;
        if (ai == 280) m_stat[3] = 1'b1;
      end
    end
  endfunction

  // One clock of the model on the currently driven inputs, then compare
  task automatic model_cycle(input int unsigned n);
    bit fr = fpga_en;
    bit cr = cpu_enable && (cpu_read || cpu_write);
    bit gf = fr && (!cr || m_fpga_turn);
    bit gc = cr && !gf;
    if (gf) m_fpga_turn = 1'b0;
    if (gc) m_fpga_turn = 1'b1;
    if (gf && !fpga_write) m_frd = m_read(fpga_addr);
    if (gc && !cpu_write)  m_crd = m_read(cpu_addr);
    if (!nrst_fpga) begin
      m_reg[220] = '0; m_reg[240] = '0; m_reg[260] = '0; m_stat = '0;
    end else if (gf && fpga_write) m_write(1'b1, fpga_addr, fpga_wdata);
    else if (gc && cpu_write) m_write(1'b0, cpu_addr, cpu_wdata);
    @(posedge clk); #1;
    chk($sformatf("rnd%0d_fack", n), {31'd0, fpga_ack}, {31'd0, gf});
    chk($sformatf("rnd%0d_cack", n), {31'd0, cpu_ack}, {31'd0, gc});
    chk($sformatf("rnd%0d_frd", n), fpga_rdata, m_frd);
    chk($sformatf("rnd%0d_crd", n), cpu_rdata, m_crd);
    chk($sformatf("rnd%0d_rr", n), {31'd0, result_ready}, {31'd0, m_stat[3]});
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    case ($urandom_range(0, 6))
      0: a = 32'd220; 1: a = 32'd240; 2: a = 32'd260; 3: a = 32'd280;
      4: a = 32'd300; 5: a = 32'd320; default: a = $urandom;
    endcase
    return a;
  endfunction

  initial begin
    // Directed vectors (from reset)
    tbl.push_back(mk(1,1,220,32'h2A, 0,0,0,0,0, 1, 1,0,0,0,0));
    tbl.push_back(mk(1,1,240,32'h07, 0,0,0,0,0, 1, 1,0,0,0,0));
    tbl.push_back(mk(1,1,260,32'h03, 0,0,0,0,0, 1, 1,0,0,0,0));
    tbl.push_back(mk(1,0,300,0,      0,0,0,0,0, 1, 1,0,32'h7,0,0));
    tbl.push_back(mk(1,0,220,0,      0,0,0,0,0, 1, 1,0,32'h2A,0,0));
    tbl.push_back(mk(0,0,0,0,        1,0,1,280,32'h31, 1, 0,1,32'h2A,0,1));
    tbl.push_back(mk(1,0,280,0,      0,0,0,0,0, 1, 1,0,32'h31,0,1));
    tbl.push_back(mk(1,0,300,0,      0,0,0,0,0, 1, 1,0,32'hF,0,1));
    // Contention: last grant was FPGA, so CPU wins the first tie
    tbl.push_back(mk(1,0,220,0,      1,1,0,240,0, 1, 0,1,32'hF,32'h7,1));
    tbl.push_back(mk(1,0,220,0,      1,1,0,240,0, 1, 1,0,32'h2A,32'h7,1));
    tbl.push_back(mk(1,0,220,0,      1,1,0,240,0, 1, 0,1,32'h2A,32'h7,1));
    tbl.push_back(mk(1,0,220,0,      1,1,0,240,0, 1, 1,0,32'h2A,32'h7,1));
    // CPU gated off
    tbl.push_back(mk(1,1,220,32'h55, 0,0,1,280,32'hDEAD, 1, 1,0,32'h2A,32'h7,1));
    tbl.push_back(mk(1,0,280,0,      0,0,1,280,32'hDEAD, 1, 1,0,32'h31,32'h7,1));
    // Read during soft clear sees pre-clear data
    tbl.push_back(mk(1,0,280,0,      0,0,0,0,0, 0, 1,0,32'h31,32'h7,0));
    tbl.push_back(mk(1,0,300,0,      0,0,0,0,0, 1, 1,0,0,32'h7,0));
    tbl.push_back(mk(1,0,220,0,      0,0,0,0,0, 1, 1,0,0,32'h7,0));
    tbl.push_back(mk(1,0,280,0,      0,0,0,0,0, 1, 1,0,32'h31,32'h7,0));
    // Unmapped address
    tbl.push_back(mk(1,1,320,32'hFFFFFFFF, 0,0,0,0,0, 1, 1,0,32'h31,32'h7,0));
    tbl.push_back(mk(1,0,320,0,      0,0,0,0,0, 1, 1,0,0,32'h7,0));
    tbl.push_back(mk(0,0,0,0,        1,1,0,320,0, 1, 0,1,0,0,0));
    tbl.push_back(mk(1,0,300,0,      0,0,0,0,0, 1, 1,0,0,0,0));
    // Write during soft clear is lost; STATUS write-1-to-clear
    tbl.push_back(mk(1,1,220,32'h99, 0,0,0,0,0, 0, 1,0,0,0,0));
    tbl.push_back(mk(1,0,220,0,      0,0,0,0,0, 1, 1,0,0,0,0));
    tbl.push_back(mk(1,1,240,32'h1,  0,0,0,0,0, 1, 1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,        1,0,1,280,32'h5, 1, 0,1,0,0,1));
    tbl.push_back(mk(0,0,0,0,        1,1,1,300,32'h8, 1, 0,1,0,0,0));
    tbl.push_back(mk(1,0,300,0,      0,0,0,0,0, 1, 1,0,32'h2,0,0));
    tbl.push_back(mk(0,0,0,0,        1,1,0,280,0, 1, 0,1,32'h2,32'h5,0));

    // Reset state
    #2;
    chk("rst_fack", {31'd0, fpga_ack}, 32'd0);
    chk("rst_cack", {31'd0, cpu_ack}, 32'd0);
    chk("rst_frd", fpga_rdata, 32'd0);
    chk("rst_crd", cpu_rdata, 32'd0);
    chk("rst_rr", {31'd0, result_ready}, 32'd0);
    #10 nrst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i].fen, tbl[i].fwr, tbl[i].fa, tbl[i].fd, tbl[i].cen, tbl[i].crd,
            tbl[i].cwr, tbl[i].ca, tbl[i].cd, tbl[i].nsc);
      @(posedge clk); #1;
      chk($sformatf("v%0d_fack", i), {31'd0, fpga_ack}, {31'd0, tbl[i].e_fack});
      chk($sformatf("v%0d_cack", i), {31'd0, cpu_ack}, {31'd0, tbl[i].e_cack});
      chk($sformatf("v%0d_frd", i), fpga_rdata, tbl[i].e_frd);
      chk($sformatf("v%0d_crd", i), cpu_rdata, tbl[i].e_crd);
      chk($sformatf("v%0d_rr", i), {31'd0, result_ready}, {31'd0, tbl[i].e_rr});
    end

    // Asynchronous reset in the middle of an access
    drive(1,0,280,0, 0,0,0,0,0, 1);
    @(posedge clk); #1;
    chk("ar_pre_ack", {31'd0, fpga_ack}, 32'd1);
    chk("ar_pre_frd", fpga_rdata, 32'h5);
    drive(1,1,220,32'h77, 0,0,0,0,0, 1);
    #2 nrst = 1'b0;
    #1;
    chk("ar_ack", {31'd0, fpga_ack}, 32'd0);
    chk("ar_frd", fpga_rdata, 32'd0);
    @(posedge clk); #1;
    chk("ar_hold_ack", {31'd0, fpga_ack}, 32'd0);
    nrst = 1'b1;
    drive(1,0,220,0, 0,0,0,0,0, 1);
    @(posedge clk); #1;
    chk("ar_num1", fpga_rdata, 32'd0);
    drive(1,0,280,0, 0,0,0,0,0, 1);
    @(posedge clk); #1;
    chk("ar_result", fpga_rdata, 32'd0);

    // Randomized traffic against the model, from a fresh reset
    drive(0,0,0,0, 0,0,0,0,0, 1);
    #2 nrst = 1'b0;
    #3 nrst = 1'b1;
    m_reset();
    @(posedge clk); #1;
    for (int unsigned n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rnd_addr(), $urandom,
            $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            rnd_addr(), $urandom, $urandom_range(0, 19) != 0);
      model_cycle(n);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
